// File: rtl/multi_key_debouncer.sv
// Multi-channel key debouncer: per-channel synchroniser, glitch-filter FSM and press/release strobes.
// Define MULTI_KEY_DEBOUNCER_AUTOREPEAT_EN to add hold-to-repeat strobes on key_repeat_stb_o.
module multi_key_debouncer #(
    parameter int unsigned CLK_FREQ_MHZ     = 100,
    parameter int unsigned GLITCH_TIME_NS   = 150,
    parameter int unsigned KEYS_CNT         = 4,
    parameter int unsigned SYNC_STAGES      = 2,
    parameter bit          KEY_ACTIVE_LOW   = 1'b1,
    parameter int unsigned HOLD_TIME_NS     = 2000,
    parameter int unsigned REPEAT_PERIOD_NS = 500
) (
    input  logic                clk_i,
    input  logic                srst_i,
    input  logic [KEYS_CNT-1:0] key_i,
    output logic [KEYS_CNT-1:0] key_state_o,
    output logic [KEYS_CNT-1:0] key_pressed_stb_o,
    output logic [KEYS_CNT-1:0] key_released_stb_o,
    output logic [KEYS_CNT-1:0] key_repeat_stb_o
);

    localparam int unsigned GlitchRaw    = (CLK_FREQ_MHZ * GLITCH_TIME_NS + 999) / 1000;
    localparam int unsigned GlitchCycles = (GlitchRaw > 0) ? GlitchRaw : 1;
    localparam int unsigned CntW         = $clog2(GlitchCycles + 1);
    localparam logic [CntW-1:0] CntLimit = CntW'(GlitchCycles);

`ifdef MULTI_KEY_DEBOUNCER_AUTOREPEAT_EN
    localparam int unsigned HoldRaw      = (CLK_FREQ_MHZ * HOLD_TIME_NS + 999) / 1000;
    localparam int unsigned HoldCycles   = (HoldRaw > 0) ? HoldRaw : 1;
    localparam int unsigned RepeatRaw    = (CLK_FREQ_MHZ * REPEAT_PERIOD_NS + 999) / 1000;
    localparam int unsigned RepeatCycles = (RepeatRaw > 0) ? RepeatRaw : 1;
    localparam int unsigned HoldMax      = (HoldCycles > RepeatCycles) ? HoldCycles : RepeatCycles;
    localparam int unsigned HoldW        = $clog2(HoldMax + 1);
    localparam logic [HoldW-1:0] HoldLimit   = HoldW'(HoldCycles);
    localparam logic [HoldW-1:0] RepeatLimit = HoldW'(RepeatCycles);
`endif

    typedef enum logic {
        StReleased,
        StPressed
    } state_e;

    for (genvar g = 0; g < KEYS_CNT; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   key_s;
        state_e                 state_q, state_d;
        logic [CntW-1:0]        cnt_q, cnt_d, cnt_inc;
        logic                   press_q, press_d;
        logic                   release_q, release_d;

        // Stages reset to the released raw level so a held key is re-detected after reset.
        always_ff @(posedge clk_i) begin
            if (srst_i) begin
                sync_q <= {SYNC_STAGES{KEY_ACTIVE_LOW}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], key_i[g]};
            end
        end

        assign key_s   = sync_q[SYNC_STAGES-1] ^ KEY_ACTIVE_LOW;
        assign cnt_inc = cnt_q + 1'b1;

        always_ff @(posedge clk_i) begin
            if (srst_i) begin
                state_q   <= StReleased;
                cnt_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        // Counter tracks the run of the opposite level; any bounce clears it.
        always_comb begin
            state_d   = state_q;
            cnt_d     = '0;
            press_d   = 1'b0;
            release_d = 1'b0;
            unique case (state_q)
                StReleased: begin
                    if (key_s) begin
                        if (cnt_inc == CntLimit) begin
                            state_d = StPressed;
                            press_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                StPressed: begin
                    if (!key_s) begin
                        if (cnt_inc == CntLimit) begin
                            state_d   = StReleased;
                            release_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: state_d = StReleased;
            endcase
        end

        assign key_state_o[g]        = (state_q == StPressed);
        assign key_pressed_stb_o[g]  = press_q;
        assign key_released_stb_o[g] = release_q;

`ifdef MULTI_KEY_DEBOUNCER_AUTOREPEAT_EN
        logic [HoldW-1:0] hold_q, hold_d, hold_inc, hold_tgt;
        logic             rep_phase_q, rep_phase_d;
        logic             rep_q, rep_d;

        assign hold_inc = hold_q + 1'b1;
        assign hold_tgt = rep_phase_q ? RepeatLimit : HoldLimit;

        // Runs only while staying in PRESSED, so the release-strobe cycle never repeats.
        always_comb begin
            hold_d      = '0;
            rep_phase_d = 1'b0;
            rep_d       = 1'b0;
            if (state_q == StPressed && state_d == StPressed) begin
                if (hold_inc == hold_tgt) begin
                    rep_d       = 1'b1;
                    rep_phase_d = 1'b1;
                end else begin
                    hold_d      = hold_inc;
                    rep_phase_d = rep_phase_q;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (srst_i) begin
                hold_q      <= '0;
                rep_phase_q <= 1'b0;
                rep_q       <= 1'b0;
            end else begin
                hold_q      <= hold_d;
                rep_phase_q <= rep_phase_d;
                rep_q       <= rep_d;
            end
        end

        assign key_repeat_stb_o[g] = rep_q;
`else
        assign key_repeat_stb_o[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Bench for multi_key_debouncer: directed scenarios and a random soak, checked every cycle against
// an event scoreboard built from the raw key timeline.
`timescale 1ns/1ps
module tb_multi_key_debouncer;
    localparam int N   = 4;
    localparam int G   = 15;
    localparam int LAT = 17;  // drive cycle to strobe-visible cycle
`ifdef MULTI_KEY_DEBOUNCER_AUTOREPEAT_EN
    localparam int HOLD = 200;
    localparam int REP  = 50;
`endif

    logic         clk = 1'b0;
    logic         srst = 1'b1;
    logic [N-1:0] key_raw = '1;
    logic [N-1:0] st, pst, rel_stb, rep_stb;

    multi_key_debouncer dut (
        .clk_i              (clk),
        .srst_i             (srst),
        .key_i              (key_raw),
        .key_state_o        (st),
        .key_pressed_stb_o  (pst),
        .key_released_stb_o (rel_stb),
        .key_repeat_stb_o   (rep_stb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int ch;
        int kind;  // 0 press, 1 release, 2 reset
    } ev_t;

    ev_t q[$];

    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;
    bit           chk_en = 1'b0;
    logic [N-1:0] m_state = '0;
    logic [N-1:0] run_lvl = '0;
    logic [N-1:0] exp_state = '0;
    int           run_len[N];
    int           run_start[N];
    int           press_at[N];
    int           c_press[N];
    int           c_rel[N];
    int           c_rep[N];
    int           all_press;
    int           multi_rel;
    int           st0_hi;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) begin
            c_press[i] = 0;
            c_rel[i]   = 0;
            c_rep[i]   = 0;
        end
        all_press = 0;
        multi_rel = 0;
        st0_hi    = 0;
    endtask

    // Check the current cycle, then drive k (pressed-sense) and srst for the next edge.
    task automatic tick(input logic [N-1:0] k, input logic r);
        logic [N-1:0] ep, er, erp;
        ev_t e;
        if (chk_en) begin
            ep  = '0;
            er  = '0;
            erp = '0;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                case (e.kind)
                    0: begin
                        ep[e.ch]        = 1'b1;
                        exp_state[e.ch] = 1'b1;
                        press_at[e.ch]  = cyc;
                    end
                    1: begin
                        er[e.ch]        = 1'b1;
                        exp_state[e.ch] = 1'b0;
                    end
                    default: exp_state = '0;
                endcase
            end
`ifdef MULTI_KEY_DEBOUNCER_AUTOREPEAT_EN
            for (int i = 0; i < N; i++) begin
                if (exp_state[i]) begin
                    int kk;
                    kk = cyc - press_at[i];
                    erp[i] = (kk >= HOLD) && ((kk - HOLD) % REP == 0);
                end
            end
`endif
            check("press_stb", pst, ep);
            check("release_stb", rel_stb, er);
            check("key_state", st, exp_state);
            check("repeat_stb", rep_stb, erp);
            for (int i = 0; i < N; i++) begin
                c_press[i] += int'(pst[i]);
                c_rel[i]   += int'(rel_stb[i]);
                c_rep[i]   += int'(rep_stb[i]);
            end
            if (pst == 4'b1111) all_press++;
            if ($countones(rel_stb) > 1) multi_rel++;
            st0_hi += int'(st[0]);
        end

        key_raw = ~k;
        srst    = r;
        if (r) begin
            while (q.size() > 0 && q[q.size()-1].cyc > cyc) void'(q.pop_back());
            q.push_back(ev_t'{cyc + 1, 0, 2});
            m_state = '0;
            run_lvl = '0;
            for (int i = 0; i < N; i++) run_len[i] = G;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (k[i] == run_lvl[i]) begin
                    if (run_len[i] < G) run_len[i]++;
                end else begin
                    run_lvl[i]   = k[i];
                    run_len[i]   = 1;
                    run_start[i] = cyc;
                end
                if (run_lvl[i] != m_state[i] && run_len[i] == G) begin
                    m_state[i] = run_lvl[i];
                    q.push_back(ev_t'{run_start[i] + LAT, i, run_lvl[i] ? 0 : 1});
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic hold(input logic [N-1:0] k, input int n);
        for (int i = 0; i < n; i++) tick(k, 1'b0);
    endtask

    initial begin
        int           rem[N];
        int           segs[N];
        logic [N-1:0] lv;
        bit           busy;

        for (int i = 0; i < N; i++) begin
            run_len[i]   = G;
            run_start[i] = 0;
            press_at[i]  = 0;
        end
        clear_stats();

        // Reset state
        for (int i = 0; i < 3; i++) tick('0, 1'b1);
        check("reset_state", st, '0);
        check("reset_press", pst, '0);
        check("reset_release", rel_stb, '0);
        check("reset_repeat", rep_stb, '0);
        chk_en = 1'b1;
        hold('0, 5);

        // ch0 pressed 100 cycles
        clear_stats();
        hold(4'b0001, 100);
        hold('0, 40);
        check_int("t1_press_cnt", c_press[0], 1);
        check_int("t1_release_cnt", c_rel[0], 1);
        check_int("t1_state_cycles", st0_hi, 100);
        check_int("t1_other_press", c_press[1] + c_press[2] + c_press[3], 0);

        // ch1 glitch widths 1..15
        clear_stats();
        for (int w = 1; w <= 15; w++) begin
            hold(4'b0010, w);
            hold('0, 20);
        end
        check_int("t2_press_cnt", c_press[1], 1);
        check_int("t2_release_cnt", c_rel[1], 1);

        // ch2 chatter then stable
        clear_stats();
        for (int i = 0; i < 30; i++) begin
            hold(4'b0100, 1);
            hold('0, 1);
        end
        hold(4'b0100, 40);
        hold('0, 40);
        check_int("t3_press_cnt", c_press[2], 1);
        check_int("t3_release_cnt", c_rel[2], 1);

        // all channels together, staggered release
        clear_stats();
        hold(4'b1111, 30);
        hold(4'b1110, 5);
        hold(4'b1100, 5);
        hold(4'b1000, 5);
        hold('0, 40);
        check_int("t4_all_press_cycles", all_press, 1);
        check_int("t4_multi_release_cycles", multi_rel, 0);
        check_int("t4_release_ch3", c_rel[3], 1);

        // reset while ch0 pressed and held
        clear_stats();
        hold(4'b0001, 30);
        tick(4'b0001, 1'b1);
        hold(4'b0001, 40);
        hold('0, 40);
        check_int("t5_press_cnt", c_press[0], 2);
        check_int("t5_release_cnt", c_rel[0], 1);

        // ch3 long hold for auto-repeat
        clear_stats();
        hold(4'b1000, LAT + 380);
        hold('0, 60);
`ifdef MULTI_KEY_DEBOUNCER_AUTOREPEAT_EN
        check_int("t6_repeat_cnt", c_rep[3], 4);
`else
        check_int("t6_repeat_cnt", c_rep[3], 0);
`endif
        check_int("t6_press_cnt", c_press[3], 1);

        // random soak
        for (int i = 0; i < N; i++) begin
            rem[i]  = 0;
            segs[i] = 0;
        end
        lv   = '0;
        busy = 1'b1;
        while (busy) begin
            busy = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && segs[i] < 500) begin
                    lv[i]  = 1'($urandom_range(0, 1));
                    rem[i] = $urandom_range(1, 40);
                    segs[i]++;
                end
            end
            tick(lv, 1'b0);
            for (int i = 0; i < N; i++) begin
                if (rem[i] > 0) rem[i]--;
                if (rem[i] > 0 || segs[i] < 500) busy = 1'b1;
            end
        end
        hold('0, 40);
        check_int("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
